// File: rtl/counter_prog_pkg.sv
// Shared types and defaults for the programmable counter.
package counter_prog_pkg;

    typedef enum logic [0:0] {
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_PRESC_W = 24;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle step every presc+1 enabled cycles; holds while disabled.
module tick_gen #(
    parameter int unsigned PRESC_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr_i,
    input  logic [PRESC_W-1:0] presc,
    output logic               step
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en) begin
            // >= also catches presc lowered below the current phase
            if (cnt_q >= presc) begin
                cnt_d = '0;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_prog.sv
// Programmable up/down counter with prescaler, modulo limit and one-shot mode.
// Optional snapshot register enabled by COUNTER_PROG_SNAP_EN.
module counter_prog
    import counter_prog_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               up,
    input  logic               oneshot,
    input  logic               clr,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [WIDTH-1:0]   limit,
    input  logic [PRESC_W-1:0] presc,
`ifdef COUNTER_PROG_SNAP_EN
    input  logic               snap,
    output logic [WIDTH-1:0]   snap_val,
`endif
    output logic [WIDTH-1:0]   cntr,
    output logic               tick,
    output logic               tc,
    output logic               running
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cntr_q, cntr_d;
    logic             tick_q, tick_d;
    logic             tc_q, tc_d;
    logic             step;
    logic             at_term;
    logic             presc_en;

    // Prescaler freezes in ST_DONE so a restart begins from a clean phase only via clr/load.
    assign presc_en = en && (state_q == ST_RUN);

    tick_gen #(
        .PRESC_W (PRESC_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (presc_en),
        .clr_i (clr | load),
        .presc (presc),
        .step  (step)
    );

    assign at_term = up ? (cntr_q >= limit) : (cntr_q == '0);

    always_comb begin
        cntr_d  = cntr_q;
        state_d = state_q;
        tick_d  = 1'b0;
        tc_d    = 1'b0;
        if (clr) begin
            cntr_d  = '0;
            state_d = ST_RUN;
        end else if (load) begin
            cntr_d  = load_val;
            state_d = ST_RUN;
        end else if (step) begin
            tick_d = 1'b1;
            if (at_term) begin
                tc_d = 1'b1;
                if (oneshot) begin
                    state_d = ST_DONE;
                end else begin
                    cntr_d = up ? '0 : limit;
                end
            end else begin
                cntr_d = up ? cntr_q + 1'b1 : cntr_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cntr_q  <= '0;
            tick_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cntr_q  <= cntr_d;
            tick_q  <= tick_d;
            tc_q    <= tc_d;
        end
    end

    assign cntr    = cntr_q;
    assign tick    = tick_q;
    assign tc      = tc_q;
    assign running = en && (state_q == ST_RUN);

`ifdef COUNTER_PROG_SNAP_EN
    logic [WIDTH-1:0] snap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
        end else if (snap) begin
            snap_q <= cntr_q;
        end
    end

    assign snap_val = snap_q;
`else
    // No capture register in this build; the count is only observable live.
`endif

endmodule

// File: tb/tb_counter_prog.sv
// Randomized and directed bench for counter_prog against a behavioural count model.
module tb_counter_prog;

    localparam int W  = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0, up = 1'b0, oneshot = 1'b0, clr = 1'b0, load = 1'b0;
    logic [W-1:0]  load_val = '0, limit = '0;
    logic [PW-1:0] presc = '0;
    logic [W-1:0]  cntr;
    logic          tick, tc, running;
`ifdef COUNTER_PROG_SNAP_EN
    logic          snap = 1'b0;
    logic [W-1:0]  snap_val;
    logic [W-1:0]  m_snap = '0;
`endif

    counter_prog #(
        .WIDTH   (W),
        .PRESC_W (PW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .oneshot  (oneshot),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .presc    (presc),
`ifdef COUNTER_PROG_SNAP_EN
        .snap     (snap),
        .snap_val (snap_val),
`endif
        .cntr     (cntr),
        .tick     (tick),
        .tc       (tc),
        .running  (running)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: count value, enabled cycles since the last step, and whether a one-shot has ended.
    logic [W-1:0] m_cnt = '0;
    int           m_phase = 0;
    bit           m_done = 1'b0;
    bit           m_tick = 1'b0;
    bit           m_tc = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = '0;
        m_phase = 0;
        m_done = 1'b0;
        m_tick = 1'b0;
        m_tc = 1'b0;
`ifdef COUNTER_PROG_SNAP_EN
        m_snap = '0;
`endif
    endtask

    // Apply the rules for one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [W-1:0] pre;
        pre = m_cnt;
        m_tick = 1'b0;
        m_tc = 1'b0;
        if (clr || load) begin
            m_cnt = clr ? '0 : load_val;
            m_phase = 0;
            m_done = 1'b0;
        end else if (en && !m_done) begin
            if (m_phase < int'(presc)) begin
                m_phase++;
            end else begin
                m_phase = 0;
                m_tick = 1'b1;
                if (up ? (m_cnt >= limit) : (m_cnt == 0)) begin
                    m_tc = 1'b1;
                    if (oneshot) m_done = 1'b1;
                    else m_cnt = up ? '0 : limit;
                end else begin
                    m_cnt = up ? m_cnt + 1'b1 : m_cnt - 1'b1;
                end
            end
        end
`ifdef COUNTER_PROG_SNAP_EN
        if (snap) m_snap = pre;
`endif
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_eq("cntr", 32'(cntr), 32'(m_cnt));
        check_eq("tick", 32'(tick), 32'(m_tick));
        check_eq("tc", 32'(tc), 32'(m_tc));
        check_eq("running", 32'(running), 32'(en && !m_done));
`ifdef COUNTER_PROG_SNAP_EN
        check_eq("snap_val", 32'(snap_val), 32'(m_snap));
`endif
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    initial begin
        int exp_up[7];
        int exp_dn[4];
        int exp_os[5];
        exp_up = '{1, 2, 3, 4, 5, 0, 1};
        exp_dn = '{1, 0, 9, 8};
        exp_os = '{1, 2, 3, 3, 3};

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_cntr", 32'(cntr), 0);
        check_eq("rst_tick", 32'(tick), 0);
        check_eq("rst_tc", 32'(tc), 0);
        check_eq("rst_running", 32'(running), 0);
        rst_n = 1'b1;

        // Wrap upward at limit 5
        en = 1'b1; up = 1'b1; presc = '0; limit = 8'd5;
        for (int i = 0; i < 7; i++) begin
            cyc();
            check_eq("up_seq", 32'(cntr), 32'(exp_up[i]));
            check_eq("up_tc", 32'(tc), 32'(i == 5));
        end

        // Prescale by 4 with an enable gap mid-period
        presc = 4'd3; limit = 8'd50;
        pulse_clr();
        repeat (6) cyc();
        en = 1'b0;
        repeat (2) cyc();
        en = 1'b1;
        repeat (10) cyc();

        // Down count from a loaded value
        presc = '0; up = 1'b0; limit = 8'd9; load_val = 8'd2; load = 1'b1;
        cyc();
        check_eq("load_val", 32'(cntr), 2);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_eq("dn_seq", 32'(cntr), 32'(exp_dn[i]));
            check_eq("dn_tc", 32'(tc), 32'(i == 2));
        end

        // One-shot stops at the terminal count, load restarts it
        up = 1'b1; oneshot = 1'b1; limit = 8'd3;
        pulse_clr();
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_eq("os_seq", 32'(cntr), 32'(exp_os[i]));
            check_eq("os_tick", 32'(tick), 32'(i < 4));
        end
        check_eq("os_running", 32'(running), 0);
        load_val = 8'd1; load = 1'b1;
        cyc();
        load = 1'b0;
        check_eq("os_restart", 32'(running), 1);
        cyc();
        check_eq("os_resume", 32'(cntr), 2);
        oneshot = 1'b0;

        // clr / load collide with a step
        limit = 8'd100;
        repeat (3) cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check_eq("clr_step_tick", 32'(tick), 0);
        repeat (2) cyc();
        load_val = 8'd42; load = 1'b1;
        cyc();
        load = 1'b0;
        check_eq("load_step_cntr", 32'(cntr), 42);

        // Asynchronous reset mid-count
        repeat (3) cyc();
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("arst_cntr", 32'(cntr), 0);
        check_eq("arst_tick", 32'(tick), 0);
        check_eq("arst_tc", 32'(tc), 0);
        check_eq("arst_running", 32'(running), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en = 1'b1;

`ifdef COUNTER_PROG_SNAP_EN
        up = 1'b1; limit = 8'd20; presc = '0;
        pulse_clr();
        repeat (7) cyc();
        snap = 1'b1;
        cyc();
        snap = 1'b0;
        check_eq("snap7", 32'(snap_val), 7);
        repeat (3) begin
            cyc();
            check_eq("snap_hold", 32'(snap_val), 7);
        end
`endif

        // Random mix, including presc changed on the fly
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom % 8) != 0;
            clr = ($urandom % 40) == 0;
            load = ($urandom % 30) == 0;
            up = 1'($urandom);
            oneshot = ($urandom % 6) == 0;
            load_val = W'($urandom);
            if ($urandom % 10 == 0) presc = PW'($urandom_range(0, 3));
            if ($urandom % 12 == 0) limit = ($urandom % 5 == 0) ? 8'hFF : W'($urandom_range(0, 15));
`ifdef COUNTER_PROG_SNAP_EN
            snap = ($urandom % 10) == 0;
`endif
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
